// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: shares one single-port image RAM between the
// VGA pixel fetch path (priority) and a valid/ready image writer. A
// starvation counter forces a pending write through during continuous
// fetching. The displaced pixel is flagged on px_miss.
module fb_port_arbiter #(
    parameter int AddressWidth = 16,
    parameter int DataWidth    = 8,
    parameter int StarveLimit  = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    px_req,
    input  logic [AddressWidth-1:0] px_addr,
    output logic [DataWidth-1:0]    px_data,
    output logic                    px_valid,
    output logic                    px_miss,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [AddressWidth-1:0] wr_addr,
    input  logic [DataWidth-1:0]    wr_data,
    output logic                    ram_rw,
    output logic [AddressWidth-1:0] ram_addr,
    output logic [DataWidth-1:0]    ram_wdata,
    input  logic [DataWidth-1:0]    ram_rdata,
    output logic                    frame_loaded
);

    localparam int CntW = (StarveLimit < 1) ? 1 : $clog2(StarveLimit + 1);
    localparam logic [CntW-1:0] Limit = CntW'(StarveLimit);

    logic [CntW-1:0] starve_cnt;
    logic            force_wr;
    logic            wr_grant;
    logic            px_grant;
    logic            miss_now;
    logic            rd_pend;
    logic            miss_pend;

    // Grant decision. Everything is gated by rst_n so the RAM never sees
    // a write strobe while the block is held in reset.
    always_comb begin
        force_wr = (StarveLimit != 0) && wr_valid && (starve_cnt == Limit);
        wr_grant = rst_n && wr_valid && (!px_req || force_wr);
        px_grant = rst_n && px_req && !wr_grant;
        miss_now = rst_n && px_req && wr_grant;
        wr_ready = wr_grant;
    end

    // RAM port drive. Reads default to px_addr so an idle cycle is a
    // harmless read.
    always_comb begin
        ram_rw    = 1'b1;
        ram_addr  = px_addr;
        ram_wdata = wr_data;
        if (!rst_n) begin
            ram_addr  = '0;
            ram_wdata = '0;
        end else if (wr_grant) begin
            ram_rw   = 1'b0;
            ram_addr = wr_addr;
        end
    end

    // Starvation counter: counts blocked cycles of a pending write, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!wr_valid || wr_grant) begin
            starve_cnt <= '0;
        end else if (starve_cnt != Limit) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Read pipeline: grant -> RAM read cycle -> px_data/px_valid two cycles on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend   <= 1'b0;
            miss_pend <= 1'b0;
            px_valid  <= 1'b0;
            px_miss   <= 1'b0;
            px_data   <= '0;
        end else begin
            rd_pend   <= px_grant;
            miss_pend <= miss_now;
            px_valid  <= rd_pend;
            px_miss   <= miss_pend;
            if (rd_pend) begin
                px_data <= ram_rdata;
            end
        end
    end

    // Sticky flag: the last word of the frame (all-ones address) was written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_loaded <= 1'b0;
        end else if (wr_grant && (&wr_addr)) begin
            frame_loaded <= 1'b1;
        end
    end

endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single-port image RAM (256x256 frame store, rw=1 read / rw=0 write, one-cycle registered read) between two requesters:
  - the VGA pixel fetch path, which has priority;
  - an image writer (e.g. a UART/SPI loader), which uses a valid/ready handshake.
- Drives the RAM's rw/addr/data_in and returns read data to the display with fixed latency.
- A starvation guard ensures the writer eventually gets the port during continuous fetching.

Parameters:
- AddressWidth, 16, RAM address bits (2**AddressWidth words).
- DataWidth, 8, RAM word width.
- StarveLimit, 255, cycles a pending write may be blocked before it is forced through; 0 disables forcing.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- px_req  input  1  display read request for this cycle.
- px_addr  input  AddressWidth  display read address.
- px_data  output  DataWidth  read data returned to display.
- px_valid  output  1  px_data valid (1-cycle pulse).
- px_miss  output  1  pulse: a display request was dropped for a forced write.
- wr_valid  input  1  writer has a word.
- wr_ready  output  1  writer granted this cycle.
- wr_addr  input  AddressWidth  write address.
- wr_data  input  DataWidth  write data.
- ram_rw  output  1  to RAM rw (1 read, 0 write).
- ram_addr  output  AddressWidth  to RAM addr.
- ram_wdata  output  DataWidth  to RAM data_in.
- ram_rdata  input  DataWidth  from RAM data_out.
- frame_loaded  output  1  sticky: a write to the all-ones address was accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - px_data=0, px_valid=0, px_miss=0, frame_loaded=0, starve_cnt=0, read pipeline cleared.
  - wr_ready=0, ram_rw=1.
  - ram_addr=0 and ram_wdata=0 combinationally.
  - No RAM write may occur while in reset.
- Grant, decided combinationally each cycle C:
  - force = (StarveLimit!=0) && wr_valid && (starve_cnt==StarveLimit).
  - Writer granted when wr_valid && (!px_req || force).
  - Otherwise the display is granted if px_req.
  - Otherwise idle: ram_rw=1, ram_addr=px_addr, no result is tracked.
- wr_ready:
  - wr_ready = writer granted; never high when wr_valid is low.
  - A transfer occurs when wr_valid && wr_ready.
- RAM drive:
  - On a write grant: ram_rw=0, ram_addr=wr_addr, ram_wdata=wr_data.
  - Otherwise: ram_rw=1, ram_addr=px_addr, ram_wdata=wr_data (don't care).
- Read pipeline:
  - A display grant in cycle C → RAM samples at the end of C → ram_rdata is valid in C+1 → registered into px_data at the end of C+1.
  - px_valid is high in C+2. Fixed latency is 2 cycles.
  - Fully pipelined: back-to-back px_req gives back-to-back px_valid.
  - px_data holds its last value when px_valid is low.
- Dropped request: if px_req is high in a cycle where force grants the writer, px_miss pulses in C+2 and px_valid stays low then. There is no retry; the display tolerates one stale pixel.
- Starvation counter, width ceil(log2(StarveLimit+1)), minimum 1:
  - Increments each cycle wr_valid && !wr_ready.
  - Saturates at StarveLimit.
  - Clears on any accepted write, or when wr_valid is low.
- frame_loaded:
  - Set on an accepted write with wr_addr == all ones.
  - Cleared only by reset.
- Reset mid-operation: in-flight reads are discarded. No px_valid or px_miss is generated after reset deasserts for grants issued before reset.
- Read-during-write ordering:
  - A read granted the cycle after a write to the same address returns the new data.
  - The arbiter never issues a read and a write in the same cycle.

Test Plan:
- Reset, then a single px_req with px_addr=0x0010, where RAM[0x0010]=0xA5 → px_valid in cycle +2 with px_data=0xA5. No wr_ready, ram_rw=1 throughout.
- px_req held for 4 cycles on addrs 0x0000..0x0003 holding 0x11,0x22,0x33,0x44 → px_valid high for 4 consecutive cycles starting +2, data in order.
- px_req low, wr_valid high with wr_addr=0x0100, wr_data=0x5A → wr_ready=1 the same cycle, ram_rw=0. A read of 0x0100 on the next cycle returns 0x5A.
- StarveLimit=3, px_req and wr_valid both held high:
  - wr_ready low for 3 cycles, high on the 4th, with ram_rw=0 that cycle.
  - px_miss pulses 2 cycles later.
  - starve_cnt returns to 0.
- Accepted write to 0xFFFF → frame_loaded=1 the next cycle and it stays 1. Asserting rst_n low clears it immediately (asynchronously).
- rst_n pulsed low one cycle after a px_req grant → no px_valid or px_miss appears afterwards. All outputs read their reset values while rst_n is low.
